// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive datapath.
// Widths, legal oversampling ratios and the mid-bit sample point.
package uart_rx_pkg;

  localparam int EDGE_W = 5;
  localparam int BIT_W  = 4;
  localparam int PS_W   = 6;

  localparam logic [PS_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PS_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PS_W-1:0] PRESCALE_32 = 6'd32;

  localparam logic [BIT_W-1:0] MAX_BIT = 4'd15;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Centre edge of a bit: Prescale/2 - 1
  function automatic logic [EDGE_W-1:0] mid_point(
    input logic [PS_W-1:0] ps
  );
    return EDGE_W'((ps >> 1) - PS_W'(1));
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and saturating bit counter.
// Both clear whenever the receive FSM drops cnt_en.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [PS_W-1:0]   Prescale,
  input  logic              cnt_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt
);

  logic edge_last;

  assign edge_last =
    (edge_cnt == EDGE_W'(Prescale - PS_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_last) begin
      edge_cnt <= '0;
      if (bit_cnt != MAX_BIT)
        bit_cnt <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART receive mid-bit sampler with 3-point majority vote.
// Counters live in uart_rx_edge_bit_counter.
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [PS_W-1:0]   Prescale,
  input  logic              RX_IN,
  input  logic              cnt_en,
  input  logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              sampled_bit,
  output logic              samp_valid
);

  logic [EDGE_W-1:0] mid;
  logic              at_s0;
  logic              at_s1;
  logic              at_vote;
  logic              s0;
  logic              s1;

  uart_rx_edge_bit_counter u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .Prescale (Prescale),
    .cnt_en   (cnt_en),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign mid     = mid_point(Prescale);
  assign at_s0   = (edge_cnt == mid - 5'd1);
  assign at_s1   = (edge_cnt == mid);
  assign at_vote = (edge_cnt == mid + 5'd1);

  // Partial captures revert to idle when counting stops
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
      samp_valid  <= 1'b0;
    end else begin
      samp_valid <= 1'b0;
      if (!cnt_en) begin
        s0 <= 1'b1;
        s1 <= 1'b1;
      end else if (dat_samp_en) begin
        unique case (1'b1)
          at_s0: s0 <= RX_IN;
          at_s1: s1 <= RX_IN;
          at_vote: begin
            sampled_bit <= maj3(s0, s1, RX_IN);
            samp_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed bench for uart_rx_edge_sampler.
// Expected votes are queued at drive time, checked on samp_valid.
module tb_uart_rx_edge_sampler;

  logic       CLK;
  logic       RST;
  logic [5:0] Prescale;
  logic       RX_IN;
  logic       cnt_en;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  typedef struct {
    logic       bitv;
    logic [4:0] edg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests  = 0;
  int   fails  = 0;
  int   nvalid = 0;
  int   v0;

  uart_rx_edge_sampler dut (
    .CLK         (CLK),
    .RST         (RST),
    .Prescale    (Prescale),
    .RX_IN       (RX_IN),
    .cnt_en      (cnt_en),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .samp_valid  (samp_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic vote(
    input logic a,
    input logic b,
    input logic c
  );
    int n;
    n = int'(a) + int'(b) + int'(c);
    return (n >= 2);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One bit of ps edges; RX_IN follows pat indexed by edge number
  task automatic run_bit(input int ps, input logic [31:0] pat);
    exp_t e;
    cnt_en = 1'b1;
    for (int k = 0; k < ps; k++) begin
      RX_IN = pat[k];
      if (dat_samp_en && k == ps / 2) begin
        e.bitv = vote(pat[ps/2-2], pat[ps/2-1], pat[ps/2]);
        e.edg  = 5'(ps / 2 + 1);
        sb.push_back(e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic idle();
    cnt_en = 1'b0;
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (samp_valid === 1'b1) begin
      nvalid++;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_valid: observed 1 expected 0");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("vote_bit", int'(sampled_bit), int'(mon_e.bitv));
        chk("vote_edge", int'(edge_cnt), int'(mon_e.edg));
      end
    end
  end

  initial begin
    logic [31:0] pat;
    RST = 1'b1;
    cnt_en = 1'b0;
    dat_samp_en = 1'b0;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    chk("rst_edge", int'(edge_cnt), 0);
    chk("rst_bit", int'(bit_cnt), 0);
    chk("rst_samp", int'(sampled_bit), 1);
    chk("rst_valid", int'(samp_valid), 0);

    RST = 1'b0;
    cnt_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk("p8_edge", int'(edge_cnt), i % 8);
      chk("p8_bit", int'(bit_cnt), i / 8);
      chk("p8_novalid", int'(samp_valid), 0);
      @(negedge CLK);
    end
    chk("p8_edge_end", int'(edge_cnt), 0);
    chk("p8_bit_end", int'(bit_cnt), 3);
    idle();
    chk("off_edge", int'(edge_cnt), 0);
    chk("off_bit", int'(bit_cnt), 0);

    Prescale = 6'd16;
    dat_samp_en = 1'b1;
    v0 = nvalid;
    run_bit(16, 32'h0000_0140);
    chk("p16_pulses", nvalid - v0, 1);
    chk("p16_bit", int'(sampled_bit), 1);
    idle();

    Prescale = 6'd32;
    v0 = nvalid;
    run_bit(32, 32'h0000_8000);
    chk("p32_pulses", nvalid - v0, 1);
    chk("p32_glitch", int'(sampled_bit), 0);
    idle();

    Prescale = 6'd8;
    v0 = nvalid;
    for (int k = 0; k < 8; k++) begin
      pat = 32'(k) << 2;
      if (!vote(pat[2], pat[3], pat[4]))
        pat = pat | 32'hE3;
      run_bit(8, pat);
    end
    chk("combo_pulses", nvalid - v0, 8);
    chk("combo_last", int'(sampled_bit), 1);
    idle();

    Prescale = 6'd16;
    RX_IN = 1'b0;
    v0 = nvalid;
    cnt_en = 1'b1;
    repeat (8) @(negedge CLK);
    cnt_en = 1'b0;
    @(negedge CLK);
    chk("drop_edge", int'(edge_cnt), 0);
    chk("drop_pulses", nvalid - v0, 0);
    chk("drop_hold", int'(sampled_bit), 1);

    Prescale = 6'd8;
    dat_samp_en = 1'b0;
    cnt_en = 1'b1;
    repeat (200) @(negedge CLK);
    chk("sat_bit", int'(bit_cnt), 15);
    chk("sat_edge", int'(edge_cnt), 0);
    idle();
    chk("sat_clr_edge", int'(edge_cnt), 0);
    chk("sat_clr_bit", int'(bit_cnt), 0);

    dat_samp_en = 1'b1;
    run_bit(8, 32'h0);
    dat_samp_en = 1'b0;
    idle();
    chk("pre_rst_samp", int'(sampled_bit), 0);

    Prescale = 6'd16;
    cnt_en = 1'b1;
    repeat (74) @(negedge CLK);
    chk("mid_edge", int'(edge_cnt), 10);
    chk("mid_bit", int'(bit_cnt), 4);
    RST = 1'b1;
    dat_samp_en = 1'b1;
    @(negedge CLK);
    chk("mrst_edge", int'(edge_cnt), 0);
    chk("mrst_bit", int'(bit_cnt), 0);
    chk("mrst_samp", int'(sampled_bit), 1);
    chk("mrst_valid", int'(samp_valid), 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_edge", int'(edge_cnt), 1);
    chk("post_rst_bit", int'(bit_cnt), 0);
    dat_samp_en = 1'b0;
    idle();

    Prescale = 6'd8;
    RX_IN = 1'b0;
    v0 = nvalid;
    cnt_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("nosamp_valid", int'(samp_valid), 0);
      @(negedge CLK);
    end
    chk("nosamp_hold", int'(sampled_bit), 1);
    chk("nosamp_pulses", nvalid - v0, 0);
    chk("nosamp_edge", int'(edge_cnt), 0);
    chk("nosamp_bit", int'(bit_cnt), 1);
    idle();
    @(negedge CLK);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
